// File: rtl/raifes_md_arbiter.sv
// Round-robin arbiter/sequencer sharing one raifes_mul_div unit between two requesters.
// One operation in flight at a time; each port may flush its own operation.
module raifes_md_arbiter #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 2,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic             req_in_1_signed_0,
  input  logic             req_in_2_signed_0,
  input  logic [OP_W-1:0]  req_op_0,
  input  logic [SEL_W-1:0] req_out_sel_0,
  input  logic [XLEN-1:0]  req_in_1_0,
  input  logic [XLEN-1:0]  req_in_2_0,
  input  logic             flush_0,
  output logic             resp_valid_0,
  input  logic             resp_ready_0,
  output logic [XLEN-1:0]  resp_result_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic             req_in_1_signed_1,
  input  logic             req_in_2_signed_1,
  input  logic [OP_W-1:0]  req_op_1,
  input  logic [SEL_W-1:0] req_out_sel_1,
  input  logic [XLEN-1:0]  req_in_1_1,
  input  logic [XLEN-1:0]  req_in_2_1,
  input  logic             flush_1,
  output logic             resp_valid_1,
  input  logic             resp_ready_1,
  output logic [XLEN-1:0]  resp_result_1,
  output logic             md_req_valid,
  input  logic             md_req_ready,
  output logic             md_req_in_1_signed,
  output logic             md_req_in_2_signed,
  output logic [OP_W-1:0]  md_req_op,
  output logic [SEL_W-1:0] md_req_out_sel,
  output logic [XLEN-1:0]  md_req_in_1,
  output logic [XLEN-1:0]  md_req_in_2,
  input  logic             md_resp_valid,
  input  logic [XLEN-1:0]  md_resp_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              discard_q, discard_d;
  logic              in_1_signed_q, in_1_signed_d;
  logic              in_2_signed_q, in_2_signed_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [XLEN-1:0]   in_1_q, in_1_d;
  logic [XLEN-1:0]   in_2_q, in_2_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic grant_valid_s;
  logic grant_s;
  logic accept_s;
  logic flush_owner_s;
  logic resp_ready_owner_s;

  // Round-robin grant: a tie goes to the port not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_valid_s = 1'b1;
      grant_s       = ~last_q;
    end else if (req_valid_0) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b0;
    end else if (req_valid_1) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  assign accept_s           = (state_q == S_IDLE) && grant_valid_s;
  assign req_ready_0        = accept_s && !grant_s;
  assign req_ready_1        = accept_s && grant_s;
  assign flush_owner_s      = owner_q ? flush_1 : flush_0;
  assign resp_ready_owner_s = owner_q ? resp_ready_1 : resp_ready_0;

  // Sequencer next-state: accept, issue, wait for the result pulse, return it.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    discard_d     = discard_q;
    in_1_signed_d = in_1_signed_q;
    in_2_signed_d = in_2_signed_q;
    op_d          = op_q;
    out_sel_d     = out_sel_q;
    in_1_d        = in_1_q;
    in_2_d        = in_2_q;
    result_d      = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d       = S_ISSUE;
          owner_d       = grant_s;
          discard_d     = 1'b0;
          in_1_signed_d = grant_s ? req_in_1_signed_1 : req_in_1_signed_0;
          in_2_signed_d = grant_s ? req_in_2_signed_1 : req_in_2_signed_0;
          op_d          = grant_s ? req_op_1 : req_op_0;
          out_sel_d     = grant_s ? req_out_sel_1 : req_out_sel_0;
          in_1_d        = grant_s ? req_in_1_1 : req_in_1_0;
          in_2_d        = grant_s ? req_in_2_1 : req_in_2_0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (flush_owner_s) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else if (md_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // The unit cannot be cancelled, so a flush only marks the result for discard.
        if (md_resp_valid) begin
          if (discard_q || flush_owner_s) begin
            state_d = S_IDLE;
            last_d  = owner_q;
          end else begin
            state_d  = S_RESP;
            result_d = md_resp_result;
          end
        end else if (flush_owner_s) begin
          discard_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (flush_owner_s || resp_ready_owner_s) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      discard_q     <= 1'b0;
      in_1_signed_q <= 1'b0;
      in_2_signed_q <= 1'b0;
      op_q          <= '0;
      out_sel_q     <= '0;
      in_1_q        <= '0;
      in_2_q        <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      discard_q     <= discard_d;
      in_1_signed_q <= in_1_signed_d;
      in_2_signed_q <= in_2_signed_d;
      op_q          <= op_d;
      out_sel_q     <= out_sel_d;
      in_1_q        <= in_1_d;
      in_2_q        <= in_2_d;
      result_q      <= result_d;
    end
  end

  // A same-cycle flush withdraws the issue request before the unit can take it.
  assign md_req_valid       = (state_q == S_ISSUE) && !flush_owner_s;
  assign md_req_in_1_signed = in_1_signed_q;
  assign md_req_in_2_signed = in_2_signed_q;
  assign md_req_op          = op_q;
  assign md_req_out_sel     = out_sel_q;
  assign md_req_in_1        = in_1_q;
  assign md_req_in_2        = in_2_q;

  assign resp_valid_0  = (state_q == S_RESP) && !owner_q;
  assign resp_valid_1  = (state_q == S_RESP) && owner_q;
  assign resp_result_0 = resp_valid_0 ? result_q : '0;
  assign resp_result_1 = resp_valid_1 ? result_q : '0;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_raifes_md_arbiter.sv
// Directed bench for raifes_md_arbiter with a behavioural 35-cycle mul/div unit model.
module tb_raifes_md_arbiter;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic        s1_0 = 1'b0, s2_0 = 1'b0, s1_1 = 1'b0, s2_1 = 1'b0;
  logic [1:0]  op_0 = 2'd0, op_1 = 2'd0, sel_0 = 2'd0, sel_1 = 2'd0;
  logic [31:0] a_0 = 32'd0, b_0 = 32'd0, a_1 = 32'd0, b_1 = 32'd0;
  logic        flush_0 = 1'b0, flush_1 = 1'b0;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
  logic [31:0] resp_result_0, resp_result_1;
  logic        md_req_valid, md_req_ready, md_s1, md_s2;
  logic [1:0]  md_op, md_sel;
  logic [31:0] md_in_1, md_in_2;
  logic        md_resp_valid;
  logic [31:0] md_resp_result;
  logic        busy;

  localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_REM = 2'd2;

  raifes_md_arbiter #(.XLEN(32), .OP_W(2), .SEL_W(2)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_in_1_signed_0(s1_0), .req_in_2_signed_0(s2_0),
    .req_op_0(op_0), .req_out_sel_0(sel_0), .req_in_1_0(a_0), .req_in_2_0(b_0),
    .flush_0(flush_0), .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
    .resp_result_0(resp_result_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_in_1_signed_1(s1_1), .req_in_2_signed_1(s2_1),
    .req_op_1(op_1), .req_out_sel_1(sel_1), .req_in_1_1(a_1), .req_in_2_1(b_1),
    .flush_1(flush_1), .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_result_1(resp_result_1),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_in_1_signed(md_s1), .md_req_in_2_signed(md_s2),
    .md_req_op(md_op), .md_req_out_sel(md_sel),
    .md_req_in_1(md_in_1), .md_req_in_2(md_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] calc(input logic [1:0] op, input logic sa, input logic sb,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_MUL:  r = a * b;
      OP_DIV:  r = (sa && sb) ? 32'($signed(a) / $signed(b)) : a / b;
      OP_REM:  r = (sa && sb) ? 32'($signed(a) % $signed(b)) : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Unit model: accepts when idle, pulses the result 34 cycles after the handshake.
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_res;
  assign md_req_ready   = !m_busy;
  assign md_resp_valid  = m_busy && (m_cnt == 0);
  assign md_resp_result = md_resp_valid ? m_res : 32'd0;
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_res <= 32'd0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end else if (md_req_valid) begin
      m_busy <= 1'b1; m_cnt <= 33; m_res <= calc(md_op, md_s1, md_s2, md_in_1, md_in_2);
    end
  end

  // Event logs: accepts, unit issues, completed result transfers.
  int          acc_port[$], acc_cyc[$], iss_cyc[$], x_port[$], x_cyc[$];
  logic [31:0] x_data[$];
  int          rv0_cnt = 0, rv1_cnt = 0;
  always @(posedge clk) begin
    if (nreset) begin
      if (req_valid_0 && req_ready_0) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (req_valid_1 && req_ready_1) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (md_req_valid && md_req_ready) iss_cyc.push_back(cyc);
      if (resp_valid_0 && resp_ready_0 && !flush_0) begin
        x_port.push_back(0); x_cyc.push_back(cyc); x_data.push_back(resp_result_0);
      end
      if (resp_valid_1 && resp_ready_1 && !flush_1) begin
        x_port.push_back(1); x_cyc.push_back(cyc); x_data.push_back(resp_result_1);
      end
      if (resp_valid_0) rv0_cnt <= rv0_cnt + 1;
      if (resp_valid_1) rv1_cnt <= rv1_cnt + 1;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    nreset = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; flush_0 = 1'b0; flush_1 = 1'b0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mdv", 32'(md_req_valid), 32'd0);
    check("rst_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    check("rst_rdy_idle", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    req_valid_1 = 1'b1;
    #1 check("rst_rdy_grant", {30'd0, req_ready_1, req_ready_0}, 32'd2);
    req_valid_1 = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic wait_rv(input int port, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((port == 0) ? resp_valid_0 : resp_valid_1) begin at = cyc; break; end
    end
  endtask

  task automatic wait_acc(input int n, input int bound);
    for (int i = 0; i < bound && acc_cyc.size() < n; i++) @(negedge clk);
    if (acc_cyc.size() < n) check("acc_timeout", 32'(acc_cyc.size()), 32'(n));
  endtask

  task automatic wait_x(input int n, input int bound);
    for (int i = 0; i < bound && x_data.size() < n; i++) @(negedge clk);
    if (x_data.size() < n) check("xfer_timeout", 32'(x_data.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, at, ba, bx, bi, r1, bad;

    // 1: single MUL on port 0
    reset_dut();
    @(negedge clk);
    t = cyc; bi = iss_cyc.size(); bx = x_data.size(); r1 = rv1_cnt;
    req_valid_0 = 1'b1; op_0 = OP_MUL; a_0 = 32'd7; b_0 = 32'd6; sel_0 = 2'd0;
    s1_0 = 1'b0; s2_0 = 1'b0; resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    #1 check("t1_ready", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    check("t1_mdv", 32'(md_req_valid), 32'd1);
    check("t1_md_in1", md_in_1, 32'd7);
    wait_rv(0, 60, at);
    check("t1_resp_cyc", 32'(at), 32'(t + 36));
    check("t1_result", resp_result_0, 32'd42);
    check("t1_other_res", resp_result_1, 32'd0);
    @(negedge clk);
    check("t1_issue_cyc", 32'(iss_cyc[bi]), 32'(t + 1));
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_xfers", 32'(x_data.size() - bx), 32'd1);
    check("t1_rv1", 32'(rv1_cnt - r1), 32'd0);

    // 2: simultaneous requests from reset, port 0 wins the first tie
    reset_dut();
    @(negedge clk);
    t = cyc; ba = acc_cyc.size(); bx = x_data.size();
    req_valid_0 = 1'b1; op_0 = OP_DIV; a_0 = 32'd100; b_0 = 32'd7; s1_0 = 1'b0; s2_0 = 1'b0;
    req_valid_1 = 1'b1; op_1 = OP_REM; a_1 = 32'hFFFF_FFF7; b_1 = 32'd4; s1_1 = 1'b1; s2_1 = 1'b1;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    #1 check("t2_ready", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    wait_acc(ba + 2, 80);
    req_valid_1 = 1'b0;
    check("t2_acc1_port", 32'(acc_port[ba + 1]), 32'd1);
    check("t2_acc1_cyc", 32'(acc_cyc[ba + 1]), 32'(t + 37));
    wait_x(bx + 2, 80);
    check("t2_x0_port", 32'(x_port[bx]), 32'd0);
    check("t2_x0_data", x_data[bx], 32'd14);
    check("t2_x1_port", 32'(x_port[bx + 1]), 32'd1);
    check("t2_x1_data", x_data[bx + 1], 32'hFFFF_FFFF);

    // 3: both ports continuously valid, grants alternate
    reset_dut();
    @(negedge clk);
    ba = acc_cyc.size(); bi = iss_cyc.size(); bx = x_data.size();
    req_valid_0 = 1'b1; op_0 = OP_MUL; a_0 = 32'd3; b_0 = 32'd5; s1_0 = 1'b0; s2_0 = 1'b0;
    req_valid_1 = 1'b1; op_1 = OP_MUL; a_1 = 32'd2; b_1 = 32'd9; s1_1 = 1'b0; s2_1 = 1'b0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    wait_acc(ba + 4, 200);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    check("t3_order", 32'({acc_port[ba][0], acc_port[ba + 1][0], acc_port[ba + 2][0], acc_port[ba + 3][0]}), 32'h5);
    for (int k = 1; k < 4; k++) begin
      check("t3_acc_gap", 32'(acc_cyc[ba + k] - acc_cyc[ba + k - 1]), 32'd37);
    end
    wait_x(bx + 4, 80);
    check("t3_iss_gap", 32'(iss_cyc[bi + 3] - iss_cyc[bi + 2]), 32'd37);
    check("t3_x0", x_data[bx], 32'd15);
    check("t3_x1", x_data[bx + 1], 32'd18);

    // 4: port 1 holds off its response for 10 cycles
    @(negedge clk);
    t = cyc; bx = x_data.size();
    req_valid_1 = 1'b1; op_1 = OP_MUL; a_1 = 32'd11; b_1 = 32'd3; resp_ready_1 = 1'b0;
    @(negedge clk);
    req_valid_1 = 1'b0;
    wait_rv(1, 60, at);
    check("t4_resp_cyc", 32'(at), 32'(t + 36));
    req_valid_0 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (!resp_valid_1 || resp_result_1 !== 32'd33 || !busy || req_ready_0) bad++;
    end
    check("t4_hold", 32'(bad), 32'd0);
    req_valid_0 = 1'b0; resp_ready_1 = 1'b1;
    wait_x(bx + 1, 5);
    check("t4_x_data", x_data[bx], 32'd33);

    // 5: flush_0 during WAIT drops the result; port 1 gets in when the unit finishes
    @(negedge clk);
    t = cyc; ba = acc_cyc.size(); bx = x_data.size(); r1 = rv0_cnt;
    req_valid_0 = 1'b1; op_0 = OP_MUL; a_0 = 32'd5; b_0 = 32'd5; resp_ready_0 = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    flush_0 = 1'b1;
    @(negedge clk);
    flush_0 = 1'b0;
    req_valid_1 = 1'b1; op_1 = OP_MUL; a_1 = 32'd4; b_1 = 32'd4; resp_ready_1 = 1'b1;
    wait_acc(ba + 2, 60);
    req_valid_1 = 1'b0;
    check("t5_acc_port", 32'(acc_port[ba + 1]), 32'd1);
    check("t5_acc_cyc", 32'(acc_cyc[ba + 1]), 32'(t + 36));
    wait_x(bx + 1, 60);
    check("t5_rv0", 32'(rv0_cnt - r1), 32'd0);
    check("t5_x_port", 32'(x_port[bx]), 32'd1);
    check("t5_x_data", x_data[bx], 32'd16);

    // 6: flush_0 has no effect on a port 1 op; flush_1 beats resp_ready_1
    @(negedge clk);
    t = cyc;
    req_valid_1 = 1'b1; op_1 = OP_MUL; a_1 = 32'd6; b_1 = 32'd7; resp_ready_1 = 1'b0;
    @(negedge clk);
    req_valid_1 = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    flush_0 = 1'b1;
    @(negedge clk);
    flush_0 = 1'b0;
    wait_rv(1, 60, at);
    check("t6_resp_cyc", 32'(at), 32'(t + 36));
    check("t6_result", resp_result_1, 32'd42);
    bx = x_data.size();
    resp_ready_1 = 1'b1; flush_1 = 1'b1;
    @(negedge clk);
    flush_1 = 1'b0; resp_ready_1 = 1'b0;
    #1;
    check("t6_idle", {30'd0, resp_valid_1, busy}, 32'd0);
    check("t6_no_xfer", 32'(x_data.size() - bx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/raifes_md_arbiter.md
# raifes_md_arbiter

Two-port arbiter and sequencer that shares a single `raifes_mul_div` unit between requesters (port 0: integer pipeline, port 1: secondary requester such as a debug or coprocessor path). It latches and issues one operation at a time to the unit, captures the single-cycle result pulse into a holding register, and returns the result to the originating port with a valid/ready handshake. Arbitration is round-robin, and each port may flush its own in-flight operation.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `OP_W`, 2, width of `op` (matches `MD_OP_WIDTH`)
- `SEL_W`, 2, width of `out_sel` (matches `MD_OUT_SEL_WIDTH`)

Ports (`i` ∈ {0,1}; requester ports are duplicated with suffix `_0` / `_1`):
- `clk` in 1: single clock; all logic rising-edge.
- `nreset` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: operation request.
- `req_ready_i` out 1: request accepted this cycle when both valid and ready are high.
- `req_in_1_signed_i`, `req_in_2_signed_i` in 1: operand signedness.
- `req_op_i` in OP_W; `req_out_sel_i` in SEL_W: operation and output select.
- `req_in_1_i`, `req_in_2_i` in XLEN: operands.
- `flush_i` in 1: discard port i's pending or in-flight operation.
- `resp_valid_i` out 1; `resp_ready_i` in 1; `resp_result_i` out XLEN: result return.
- `md_req_valid` out 1; `md_req_ready` in 1: unit request handshake.
- `md_req_in_1_signed`, `md_req_in_2_signed` out 1; `md_req_op` out OP_W; `md_req_out_sel` out SEL_W; `md_req_in_1`, `md_req_in_2` out XLEN: to unit.
- `md_resp_valid` in 1 (single-cycle pulse); `md_resp_result` in XLEN: from unit.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: `owner` (1 b), `last` (1 b, last port served), `discard` (1 b), latched request fields, `result` (XLEN).
- IDLE: the grant is combinational.
  - Only one port valid → grant it.
  - Both valid → grant `!last`.
  - `req_ready_i` = (state==IDLE) && grant==i. Only one port is ever ready.
  - On accept: latch all request fields, set `owner`, clear `discard`, go to ISSUE.
- ISSUE: `md_req_valid`=1 with the latched fields.
  - `md_req_ready` high → WAIT.
  - `flush_owner` → IDLE without issuing. Flush takes priority over issue, and `md_req_valid` is suppressed that cycle.
- WAIT:
  - `flush_owner` → set `discard`.
  - On `md_resp_valid`: `discard` (or flush in the same cycle) → IDLE. Otherwise capture `md_resp_result` into `result` and go to RESP.
- RESP: `resp_valid_owner`=1, `resp_result_owner`=`result`.
  - `resp_ready_owner` → IDLE, `last`←`owner`.
  - `flush_owner` → IDLE with no transfer. Flush wins over ready in the same cycle. `last`←`owner`.
- Flush of the non-owner port, or any flush in IDLE, has no effect.
- `md_resp_valid` outside WAIT is ignored.
- `resp_result_i` of the non-owner port is driven to 0.
- `last` also updates to `owner` on flush-exit from ISSUE or WAIT.

## Timing
- Reset (async assert, sync-released by top level): state=IDLE, `last`=1 (port 0 wins the first tie), `owner`=0, `discard`=0, `result`=0.
- All outputs are 0 during reset except the combinational `req_ready_i`, which follows the IDLE grant (0 while no request is valid).
- The unit's reset is driven from the same reset source, so reset mid-operation leaves both blocks idle.
- Accept at cycle T, then `md_req_valid` at T+1. With `raifes_mul_div` idle (fixed 35-cycle accept-to-`resp_valid`), `md_resp_valid` arrives at T+35 and `resp_valid_owner` rises at T+36.
- `resp_valid` holds until ready. With ready high at T+36, the next accept is possible at T+37. Minimum issue-to-issue spacing is 37 cycles.
- Request inputs need only be stable in the accept cycle. Outputs to the unit come from registers; there is no combinational path from requester inputs to `md_*`.

## Test plan
- Single MUL on port 0 (in_1=7, in_2=6, out_sel LO) → `req_ready_0` at T, `md_req_valid` at T+1, `resp_valid_0` at T+36 with result 42. `resp_valid_1` stays 0.
- Both ports valid in the same cycle from reset (port 0 DIV 100/7, port 1 REM −9/4 signed) → port 0 is served first with result 14. Port 1 is then accepted in the cycle after the port 0 response handshake, with result −1 (0xFFFFFFFF).
- Both ports continuously valid for 4 ops → grants alternate 0, 1, 0, 1. Each issue is 37 cycles after the previous one when `resp_ready` is held high.
- `resp_ready_1` held low for 10 cycles after the result → `resp_valid_1` and `result` stay stable. `busy`=1 and `req_ready_0`=0 throughout.
- `flush_0` during WAIT (cycle T+10) → no `resp_valid_0`. State returns to IDLE at T+36. A subsequent port 1 request is accepted at T+36.
- `flush_1` in the same cycle as `resp_ready_1` in RESP → no transfer counted, IDLE next cycle. `flush_0` during a port 1 operation → no effect.
